// File: rtl/dff_pipe_pkg.sv
// Purpose  : shared defaults and helpers for the dff_pipe elastic register pipeline.
// Latency  : n/a (package only).
// Backpres.: n/a (package only).
// Contents : default WIDTH/DEPTH, occ_width() used to size the optional occupancy port.
package dff_pipe_pkg;

   localparam int DFF_PIPE_WIDTH = 8;
   localparam int DFF_PIPE_DEPTH = 4;

   // Bits needed to count 0..depth valid stages inclusive.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// Purpose  : one data+valid register of the dff_pipe chain.
// Latency  : 1 cycle from in_* to out_* when adv=1.
// Backpres.: holds contents while adv=0; flush clears valid only, data is kept.
// Ports    : clk, reset (sync, active-high), flush, adv (stage may load),
//            in_vld/in_dat (from upstream stage or producer), out_vld/out_dat (stage contents).
module dff_pipe_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             adv,
   input  logic             in_vld,
   input  logic [WIDTH-1:0] in_dat,
   output logic             out_vld,
   output logic [WIDTH-1:0] out_dat
);

   logic             v_d,    v_q;
   logic [WIDTH-1:0] data_d, data_q;

   always_comb begin
      v_d    = v_q;
      data_d = data_q;
      if (flush) begin
         v_d = 1'b0;
      end else if (adv) begin
         v_d = in_vld;
         // Data only moves with a valid beat; a bubble clears v but leaves data parked.
         if (in_vld) begin
            data_d = in_dat;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v_q    <= 1'b0;
         data_q <= '0;
      end else begin
         v_q    <= v_d;
         data_q <= data_d;
      end
   end

   assign out_vld = v_q;
   assign out_dat = data_q;

endmodule

// File: rtl/dff_pipe.sv
// Purpose  : WIDTH-bit, DEPTH-stage elastic register pipeline with q/qb outputs and flush.
// Latency  : DEPTH cycles from input accept to q when not stalled; 1 beat/cycle throughput.
// Backpres.: combinational ready chain; empty stages advance under a stall (bubble collapse).
// Ports    : clk, reset (sync, active-high), flush, d/d_valid/d_ready (producer side),
//            q/qb/q_valid/q_ready (consumer side), occupancy (only with DFF_PIPE_OCCUPANCY_EN).
// Option   : define DFF_PIPE_OCCUPANCY_EN to add the registered valid-stage count output.
module dff_pipe
   import dff_pipe_pkg::*;
#(
   parameter int WIDTH = DFF_PIPE_WIDTH,
   parameter int DEPTH = DFF_PIPE_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic [WIDTH-1:0] d,
   input  logic             d_valid,
   output logic             d_ready,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             q_valid,
   input  logic             q_ready
`ifdef DFF_PIPE_OCCUPANCY_EN
   ,
   output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

   logic [DEPTH-1:0] v;
   logic [WIDTH-1:0] dat [DEPTH];
   logic [DEPTH-1:0] adv;

   // adv[i] = ~v[i] | adv[i+1] unrolled: stage i may advance when the consumer
   // takes q or any stage from i to the output is empty. Written flat so the
   // chain has no bit-to-bit feedback inside one vector.
   always_comb begin
      adv = '0;
      for (int i = 0; i < DEPTH; i++) begin
         adv[i] = q_ready;
         for (int j = i; j < DEPTH; j++) begin
            adv[i] = adv[i] | ~v[j];
         end
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             in_vld;
      logic [WIDTH-1:0] in_dat;

      if (i == 0) begin : g_head
         assign in_vld = d_valid;
         assign in_dat = d;
      end else begin : g_body
         assign in_vld = v[i-1];
         assign in_dat = dat[i-1];
      end

      dff_pipe_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk     (clk),
         .reset   (reset),
         .flush   (flush),
         .adv     (adv[i]),
         .in_vld  (in_vld),
         .in_dat  (in_dat),
         .out_vld (v[i]),
         .out_dat (dat[i])
      );
   end

   assign d_ready = adv[0];
   assign q       = dat[DEPTH-1];
   assign qb      = ~q;
   assign q_valid = v[DEPTH-1];

`ifdef DFF_PIPE_OCCUPANCY_EN
   localparam int OW = occ_width(DEPTH);
   localparam logic [OW-1:0] OCC_MAX = OW'(DEPTH);

   logic          in_xfer, out_xfer;
   logic [OW-1:0] occ_d, occ_q;

   assign in_xfer  = d_valid & d_ready;
   assign out_xfer = q_valid & q_ready;

   always_comb begin
      occ_d = occ_q;
      if (flush) begin
         occ_d = '0;
      end else if (in_xfer && !out_xfer) begin
         occ_d = occ_q + OW'(1);
      end else if (out_xfer && !in_xfer) begin
         occ_d = occ_q - OW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occupancy = occ_q;

   a_occ_bound : assert property (@(posedge clk) disable iff (reset) occ_q <= OCC_MAX);
`endif

endmodule
